// File: rtl/control_sequencer.sv
// NSC-8 microcoded control unit: a T-state counter with a halt latch, and a
// combinational decode of one datapath control word per step.
module control_sequencer #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N/2-1:0]   opcode,
    input  logic             carry_flag,
    input  logic             zero_flag,
    output logic [2:0]       step,
    output logic             halt,
    output logic             memory_address_in,
    output logic             ram_out,
    output logic             ram_in,
    output logic             load_ir,
    output logic             output_enable_ir,
    output logic             a_in,
    output logic             a_out,
    output logic             b_in,
    output logic             alu_out,
    output logic             subtract,
    output logic             flags_in,
    output logic             output_in,
    output logic             counter_enable,
    output logic             counter_out,
    output logic             jump
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } op_t;

    step_t      state;
    logic       halted;
    logic [3:0] op;

    assign op   = opcode[3:0];
    assign step = state;

    // Sequencing: instruction length is decided from the opcode at T2/T3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= T0;
            halted <= 1'b0;
        end else if (!halted) begin
            case (state)
                T0: state <= T1;
                T1: state <= T2;
                T2: begin
                    if (op == OP_HLT) begin
                        halted <= 1'b1;
                    end else if (op == OP_LDA || op == OP_STA ||
                                 op == OP_ADD || op == OP_SUB) begin
                        state <= T3;
                    end else begin
                        state <= T0;
                    end
                end
                T3: begin
                    if (op == OP_ADD || op == OP_SUB) state <= T4;
                    else                              state <= T0;
                end
                T4:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    always_comb begin
        halt              = 1'b0;
        memory_address_in = 1'b0;
        ram_out           = 1'b0;
        ram_in            = 1'b0;
        load_ir           = 1'b0;
        output_enable_ir  = 1'b0;
        a_in              = 1'b0;
        a_out             = 1'b0;
        b_in              = 1'b0;
        alu_out           = 1'b0;
        subtract          = 1'b0;
        flags_in          = 1'b0;
        output_in         = 1'b0;
        counter_enable    = 1'b0;
        counter_out       = 1'b0;
        jump              = 1'b0;
        if (!reset) begin
            if (halted) begin
                halt = 1'b1;
            end else begin
                case (state)
                    T0: begin
                        counter_out       = 1'b1;
                        memory_address_in = 1'b1;
                    end
                    T1: begin
                        ram_out        = 1'b1;
                        load_ir        = 1'b1;
                        counter_enable = 1'b1;
                    end
                    T2: begin
                        case (op)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                output_enable_ir  = 1'b1;
                                memory_address_in = 1'b1;
                            end
                            OP_LDI: begin
                                output_enable_ir = 1'b1;
                                a_in             = 1'b1;
                            end
                            OP_JMP: begin
                                output_enable_ir = 1'b1;
                                jump             = 1'b1;
                            end
                            OP_JC: begin
                                output_enable_ir = 1'b1;
                                jump             = carry_flag;
                            end
                            OP_JZ: begin
                                output_enable_ir = 1'b1;
                                jump             = zero_flag;
                            end
                            OP_OUT: begin
                                a_out     = 1'b1;
                                output_in = 1'b1;
                            end
                            OP_HLT:  halt = 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (op)
                            OP_LDA: begin
                                ram_out = 1'b1;
                                a_in    = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                ram_out = 1'b1;
                                b_in    = 1'b1;
                            end
                            OP_STA: begin
                                a_out  = 1'b1;
                                ram_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (op == OP_ADD || op == OP_SUB) begin
                            alu_out  = 1'b1;
                            a_in     = 1'b1;
                            flags_in = 1'b1;
                            subtract = (op == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
